// File: rtl/vrf_read_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_port_scheduler_if
// Description : Request/release/lending bus between the vector drivers and
//               the VRF read-port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface vrf_read_port_scheduler_if #(
  parameter int W_PORTS_NUM = 4,
  parameter int R_PORTS_NUM = 2 * W_PORTS_NUM
);
  localparam int c_DRV_W  = $clog2(W_PORTS_NUM);
  localparam int c_PORT_W = $clog2(R_PORTS_NUM);

  logic [W_PORTS_NUM-1:0]               req_i;
  logic [W_PORTS_NUM-1:0]               rel_i;
  logic [W_PORTS_NUM-1:0]               idle_i;
  logic [W_PORTS_NUM-1:0]               grant_o;
  logic [W_PORTS_NUM-1:0][c_PORT_W-1:0] granted_port_o;
  logic [R_PORTS_NUM-1:0][c_DRV_W-1:0]  read_port_allocation_o;
  logic [R_PORTS_NUM-1:0]               primary_read_data_o;
  logic [W_PORTS_NUM-1:0]               owner_blocked_o;

  // Driver side: issues requests/releases, observes the allocation.
  modport master (
    output req_i, rel_i, idle_i,
    input  grant_o, granted_port_o, read_port_allocation_o,
           primary_read_data_o, owner_blocked_o
  );

  // Scheduler side.
  modport slave (
    input  req_i, rel_i, idle_i,
    output grant_o, granted_port_o, read_port_allocation_o,
           primary_read_data_o, owner_blocked_o
  );
endinterface
`default_nettype wire

// File: rtl/vrf_read_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_port_scheduler
// Description : Lends idle drivers' VRF read ports to drivers that need a
//               third operand port. Round-robin among requesters, lowest
//               eligible port wins, loans last until an explicit release.
//               Requires W_PORTS_NUM >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_read_port_scheduler #(
  parameter int W_PORTS_NUM = 4,
  parameter int R_PORTS_NUM = 2 * W_PORTS_NUM
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  vrf_read_port_scheduler_if.slave bus
);
  localparam int c_DRV_W  = $clog2(W_PORTS_NUM);
  localparam int c_PORT_W = $clog2(R_PORTS_NUM);

  // Per-port loan state
  logic [R_PORTS_NUM-1:0]               r_lent;
  logic [R_PORTS_NUM-1:0][c_DRV_W-1:0]  r_holder;
  // Per-driver hold state
  logic [W_PORTS_NUM-1:0]               r_held;
  logic [W_PORTS_NUM-1:0][c_PORT_W-1:0] r_granted_port;
  logic [W_PORTS_NUM-1:0]               r_grant;
  logic [c_DRV_W-1:0]                   r_rr_ptr;

  logic [W_PORTS_NUM-1:0]               w_rel_eff;
  logic [R_PORTS_NUM-1:0]               w_rel_port;
  logic [R_PORTS_NUM-1:0]               w_port_free;
  logic [W_PORTS_NUM-1:0]               w_has_port;
  logic [W_PORTS_NUM-1:0][c_PORT_W-1:0] w_low_port;
  logic [W_PORTS_NUM-1:0]               w_cand;
  logic                                 w_any;
  logic [c_DRV_W-1:0]                   w_any_idx;
  logic                                 w_hi;
  logic [c_DRV_W-1:0]                   w_hi_idx;
  logic                                 w_grant_vld;
  logic [c_DRV_W-1:0]                   w_win;
  logic [c_PORT_W-1:0]                  w_win_port;

  // A release from a driver that holds nothing is meaningless and dropped.
  assign w_rel_eff = bus.rel_i & r_held;

  // Mark the ports being released this cycle; they are not re-lendable until next cycle.
  always_comb begin
    w_rel_port = '0;
    for (int j = 0; j < W_PORTS_NUM; j++) begin
      for (int k = 0; k < R_PORTS_NUM; k++) begin
        if (w_rel_eff[j] && (r_granted_port[j] == c_PORT_W'(k))) begin
          w_rel_port[k] = 1'b1;
        end
      end
    end
  end

  // A port can be lent only when it is free, its owner is idle and no release hits it.
  for (genvar k = 0; k < R_PORTS_NUM; k++) begin : g_free
    assign w_port_free[k] = ~r_lent[k] & bus.idle_i[k/2] & ~w_rel_port[k];
  end

  // For every driver, find the lowest free port not owned by that driver.
  always_comb begin
    w_has_port = '0;
    w_low_port = '0;
    for (int j = 0; j < W_PORTS_NUM; j++) begin
      for (int k = R_PORTS_NUM - 1; k >= 0; k--) begin
        if (w_port_free[k] && ((k / 2) != j)) begin
          w_has_port[j] = 1'b1;
          w_low_port[j] = c_PORT_W'(k);
        end
      end
    end
  end

  // Requests from drivers already holding a port are ignored.
  assign w_cand = bus.req_i & ~r_held & w_has_port;

  // Rotating priority: lowest candidate at/after rr_ptr, otherwise lowest overall.
  always_comb begin
    w_any     = 1'b0;
    w_any_idx = '0;
    w_hi      = 1'b0;
    w_hi_idx  = '0;
    for (int j = W_PORTS_NUM - 1; j >= 0; j--) begin
      if (w_cand[j]) begin
        w_any     = 1'b1;
        w_any_idx = c_DRV_W'(j);
        if (j >= int'(r_rr_ptr)) begin
          w_hi     = 1'b1;
          w_hi_idx = c_DRV_W'(j);
        end
      end
    end
  end

  assign w_grant_vld = w_any;
  assign w_win       = w_hi ? w_hi_idx : w_any_idx;
  assign w_win_port  = w_low_port[w_win];

  // Loan bookkeeping: apply releases, then record at most one new grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lent         <= '0;
      r_holder       <= '0;
      r_held         <= '0;
      r_granted_port <= '0;
      r_grant        <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_grant <= '0;
      for (int j = 0; j < W_PORTS_NUM; j++) begin
        if (w_rel_eff[j]) begin
          r_held[j] <= 1'b0;
        end
      end
      for (int k = 0; k < R_PORTS_NUM; k++) begin
        if (w_rel_port[k]) begin
          r_lent[k] <= 1'b0;
        end
      end
      // The winner never releases in the same cycle (it holds nothing) and
      // its port is never a released one, so these writes cannot collide.
      if (w_grant_vld) begin
        r_grant[w_win]        <= 1'b1;
        r_held[w_win]         <= 1'b1;
        r_lent[w_win_port]    <= 1'b1;
        r_holder[w_win_port]  <= w_win;
        r_granted_port[w_win] <= w_win_port;
        r_rr_ptr <= (w_win == c_DRV_W'(W_PORTS_NUM - 1)) ? '0 : (w_win + c_DRV_W'(1));
      end
    end
  end

  assign bus.grant_o        = r_grant;
  assign bus.granted_port_o = r_granted_port;

  // Per-port mux: a lent port is addressed by its holder, otherwise by its owner.
  for (genvar k = 0; k < R_PORTS_NUM; k++) begin : g_port_out
    assign bus.primary_read_data_o[k]    = ~r_lent[k];
    assign bus.read_port_allocation_o[k] = r_lent[k] ? r_holder[k] : c_DRV_W'(k / 2);
  end

  // An owner with any port out on loan must not start a new instruction.
  for (genvar w = 0; w < W_PORTS_NUM; w++) begin : g_owner
    assign bus.owner_blocked_o[w] = r_lent[2*w] | r_lent[2*w+1];
  end

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_read_port_scheduler
// Description : Directed self-checking bench for vrf_read_port_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_read_port_scheduler;
  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_bad;

  vrf_read_port_scheduler_if #(.W_PORTS_NUM(4), .R_PORTS_NUM(8)) u_if ();

  vrf_read_port_scheduler #(.W_PORTS_NUM(4), .R_PORTS_NUM(8)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (u_if.primary_read_data_o !== 8'hFF) begin
      n_bad++; $display("FAIL reset_primary: got %h want ff", u_if.primary_read_data_o);
    end
    n_checks++;
    if (u_if.read_port_allocation_o !== 16'hFA50) begin
      n_bad++; $display("FAIL reset_alloc: got %h want fa50", u_if.read_port_allocation_o);
    end
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.owner_blocked_o !== 4'b0000) begin
      n_bad++; $display("FAIL reset_grant_blocked: got %b/%b want 0000/0000", u_if.grant_o, u_if.owner_blocked_o);
    end
    n_checks++;
    if (u_if.granted_port_o !== 12'h000) begin
      n_bad++; $display("FAIL reset_granted_port: got %h want 000", u_if.granted_port_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_single_grant();
    u_if.req_i  = 4'b0001;
    u_if.idle_i = 4'b1110;
    tick();
    u_if.req_i = 4'b0000;
    n_checks++;
    if (u_if.grant_o !== 4'b0001 || u_if.granted_port_o[0] !== 3'd2) begin
      n_bad++; $display("FAIL single_grant: got grant=%b port=%0d want 0001/2", u_if.grant_o, u_if.granted_port_o[0]);
    end
    n_checks++;
    if (u_if.primary_read_data_o !== 8'hFB || u_if.read_port_allocation_o[2] !== 2'd0) begin
      n_bad++; $display("FAIL single_alloc: got prim=%h alloc2=%0d want fb/0", u_if.primary_read_data_o, u_if.read_port_allocation_o[2]);
    end
    n_checks++;
    if (u_if.owner_blocked_o !== 4'b0010) begin
      n_bad++; $display("FAIL single_blocked: got %b want 0010", u_if.owner_blocked_o);
    end
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFB) begin
      n_bad++; $display("FAIL single_pulse: got grant=%b prim=%h want 0000/fb", u_if.grant_o, u_if.primary_read_data_o);
    end
  endtask

  task automatic test_release();
    // Driver 2 takes port 3 so that no other port is free when port 2 is released.
    u_if.req_i = 4'b0100;
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b0100 || u_if.granted_port_o[2] !== 3'd3) begin
      n_bad++; $display("FAIL second_grant: got grant=%b port=%0d want 0100/3", u_if.grant_o, u_if.granted_port_o[2]);
    end
    u_if.rel_i  = 4'b0101;
    u_if.req_i  = 4'b1000;
    u_if.idle_i = 4'b0010;
    tick();
    u_if.rel_i = 4'b0000;
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFF || u_if.owner_blocked_o !== 4'b0000) begin
      n_bad++; $display("FAIL release_same_cycle: got grant=%b prim=%h blk=%b want 0000/ff/0000", u_if.grant_o, u_if.primary_read_data_o, u_if.owner_blocked_o);
    end
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b1000 || u_if.granted_port_o[3] !== 3'd2) begin
      n_bad++; $display("FAIL release_regrant: got grant=%b port=%0d want 1000/2", u_if.grant_o, u_if.granted_port_o[3]);
    end
    // Request while holding is ignored.
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFB) begin
      n_bad++; $display("FAIL req_while_held: got grant=%b prim=%h want 0000/fb", u_if.grant_o, u_if.primary_read_data_o);
    end
  endtask

  task automatic test_rel_req_same();
    u_if.rel_i = 4'b1000;
    tick();
    u_if.rel_i = 4'b0000;
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFF) begin
      n_bad++; $display("FAIL rel_req_release_only: got grant=%b prim=%h want 0000/ff", u_if.grant_o, u_if.primary_read_data_o);
    end
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b1000 || u_if.read_port_allocation_o[2] !== 2'd3) begin
      n_bad++; $display("FAIL rel_req_reeval: got grant=%b alloc2=%0d want 1000/3", u_if.grant_o, u_if.read_port_allocation_o[2]);
    end
    u_if.req_i = 4'b0000;
    u_if.rel_i = 4'b1001;
    tick();
    u_if.rel_i = 4'b0000;
    n_checks++;
    if (u_if.primary_read_data_o !== 8'hFF || u_if.owner_blocked_o !== 4'b0000) begin
      n_bad++; $display("FAIL release_unheld_ignored: got prim=%h blk=%b want ff/0000", u_if.primary_read_data_o, u_if.owner_blocked_o);
    end
  endtask

  task automatic test_round_robin();
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    u_if.req_i  = 4'b0110;
    u_if.idle_i = 4'b1001;
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b0010 || u_if.granted_port_o[1] !== 3'd0) begin
      n_bad++; $display("FAIL rr_first: got grant=%b port=%0d want 0010/0", u_if.grant_o, u_if.granted_port_o[1]);
    end
    tick();
    u_if.req_i = 4'b0000;
    n_checks++;
    if (u_if.grant_o !== 4'b0100 || u_if.granted_port_o[2] !== 3'd1) begin
      n_bad++; $display("FAIL rr_second: got grant=%b port=%0d want 0100/1", u_if.grant_o, u_if.granted_port_o[2]);
    end
    n_checks++;
    if (u_if.read_port_allocation_o[0] !== 2'd1 || u_if.read_port_allocation_o[1] !== 2'd2 || u_if.owner_blocked_o !== 4'b0001) begin
      n_bad++; $display("FAIL rr_alloc: got a0=%0d a1=%0d blk=%b want 1/2/0001", u_if.read_port_allocation_o[0], u_if.read_port_allocation_o[1], u_if.owner_blocked_o);
    end
  endtask

  task automatic test_idle_drop_and_async_reset();
    u_if.idle_i = 4'b0000;
    tick();
    n_checks++;
    if (u_if.primary_read_data_o !== 8'hFC || u_if.owner_blocked_o !== 4'b0001) begin
      n_bad++; $display("FAIL idle_drop_keeps_loan: got prim=%h blk=%b want fc/0001", u_if.primary_read_data_o, u_if.owner_blocked_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (u_if.primary_read_data_o !== 8'hFF || u_if.read_port_allocation_o !== 16'hFA50) begin
      n_bad++; $display("FAIL async_reset_alloc: got prim=%h alloc=%h want ff/fa50", u_if.primary_read_data_o, u_if.read_port_allocation_o);
    end
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.owner_blocked_o !== 4'b0000 || u_if.granted_port_o !== 12'h000) begin
      n_bad++; $display("FAIL async_reset_outs: got grant=%b blk=%b gp=%h want 0/0/0", u_if.grant_o, u_if.owner_blocked_o, u_if.granted_port_o);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_starvation();
    u_if.req_i  = 4'b0010;
    u_if.idle_i = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFF) begin
        n_bad++; $display("FAIL starve_cycle%0d: got grant=%b prim=%h want 0000/ff", c, u_if.grant_o, u_if.primary_read_data_o);
      end
    end
    u_if.idle_i = 4'b0011;
    tick();
    u_if.req_i = 4'b0000;
    n_checks++;
    if (u_if.grant_o !== 4'b0010 || u_if.granted_port_o[1] !== 3'd0) begin
      n_bad++; $display("FAIL starve_recover: got grant=%b port=%0d want 0010/0", u_if.grant_o, u_if.granted_port_o[1]);
    end
    tick();
    n_checks++;
    if (u_if.grant_o !== 4'b0000 || u_if.primary_read_data_o !== 8'hFE) begin
      n_bad++; $display("FAIL starve_pulse: got grant=%b prim=%h want 0000/fe", u_if.grant_o, u_if.primary_read_data_o);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_bad       = 0;
    rst_i       = 1'b1;
    u_if.req_i  = '0;
    u_if.rel_i  = '0;
    u_if.idle_i = '0;
    test_reset();
    test_single_grant();
    test_release();
    test_rel_req_same();
    test_round_robin();
    test_idle_drop_and_async_reset();
    test_starvation();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
